// File: rtl/frame_capture_pkg.sv
// Shared types and helpers for the frame-capture sequencer.
package frame_capture_pkg;

  localparam int FRAME_IDX_W = 16;
  localparam int PX_X_W      = 9;
  localparam int PX_Y_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SKIP   = 3'd2,
    ST_RECORD = 3'd3,
    ST_DONE   = 3'd4
  } cap_state_t;

  // Number of pixels in a complete frame.
  function automatic int px_total(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Per-frame pixel position tracker: column/row of the next pixel, pixel
// count and an overflow flag for frames carrying more than W*H pixels.
// A clear and an increment in the same cycle count the pixel as the
// first one of the freshly cleared frame.
module frame_pixel_counter
  import frame_capture_pkg::*;
#(
  parameter int W = 256,
  parameter int H = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic              wr_ok,
  output logic [PX_X_W-1:0] wr_x,
  output logic [PX_Y_W-1:0] wr_y,
  output logic              short_frame,
  output logic              ovf
);

  localparam int TOTAL = px_total(W, H);
  localparam int CNT_W = $clog2(TOTAL + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_b;
  logic [PX_X_W-1:0] x_q, x_d, x_b;
  logic [PX_Y_W-1:0] y_q, y_d, y_b;
  logic              ovf_q, ovf_d, ovf_b;

  // Apply clear first, then accept or flag the incoming pixel.
  always_comb begin
    cnt_b = clr ? '0   : cnt_q;
    x_b   = clr ? '0   : x_q;
    y_b   = clr ? '0   : y_q;
    ovf_b = clr ? 1'b0 : ovf_q;
    cnt_d = cnt_b;
    x_d   = x_b;
    y_d   = y_b;
    ovf_d = ovf_b;
    wr_ok = 1'b0;
    if (inc) begin
      if (cnt_b < CNT_W'(TOTAL)) begin
        wr_ok = 1'b1;
        cnt_d = cnt_b + CNT_W'(1);
        if (x_b == PX_X_W'(W - 1)) begin
          x_d = '0;
          y_d = y_b + PX_Y_W'(1);
        end else begin
          x_d = x_b + PX_X_W'(1);
        end
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Position, count and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
      y_q   <= y_d;
      ovf_q <= ovf_d;
    end
  end

  assign wr_x        = x_b;
  assign wr_y        = y_b;
  assign short_frame = cnt_q < CNT_W'(TOTAL);
  assign ovf         = ovf_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame-capture sequencer: picks which PPU frames are recorded (start,
// stop, decimation), gates pixel strobes into write enables with x/y
// coordinates, and flags frames whose pixel count is not W*H.
module frame_capture_ctrl
  import frame_capture_pkg::*;
#(
  parameter int IMAGE_W     = 256,
  parameter int IMAGE_H     = 240,
  parameter int START_FRAME = 0,
  parameter int STOP_FRAME  = 2,
  parameter int DECIMATE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        abort,
  input  logic        frame,
  input  logic        pixel_en,
  output logic        px_we,
  output logic [8:0]  px_x,
  output logic [7:0]  px_y,
  output logic        rec_start,
  output logic        rec_end,
  output logic [15:0] rec_frame,
  output logic        err_short,
  output logic        err_long,
  output logic        busy,
  output logic        done
);

  localparam logic [FRAME_IDX_W-1:0] START_IDX = FRAME_IDX_W'(START_FRAME);
  localparam logic [FRAME_IDX_W-1:0] STOP_IDX  = FRAME_IDX_W'(STOP_FRAME);
  localparam logic [FRAME_IDX_W-1:0] DEC_LAST  = FRAME_IDX_W'(DECIMATE - 1);

  cap_state_t             state_q, state_d;
  logic                   frame_q;
  logic [FRAME_IDX_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRAME_IDX_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [FRAME_IDX_W-1:0] rec_frame_q, rec_frame_d;
  logic                   rec_start_q, rec_start_d;
  logic                   rec_end_q, rec_end_d;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q, err_long_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   px_we_q, px_we_d;
  logic [PX_X_W-1:0]      px_x_q, px_x_d;
  logic [PX_Y_W-1:0]      px_y_q, px_y_d;

  logic                   sof;
  logic                   decide;
  logic                   start_rec;
  logic                   cnt_clr;
  logic                   cnt_inc;
  logic                   eligible;
  logic [FRAME_IDX_W-1:0] n_idx;
  logic                   wr_ok;
  logic [PX_X_W-1:0]      wr_x;
  logic [PX_Y_W-1:0]      wr_y;
  logic                   short_frame;
  logic                   ovf;

  assign sof = frame & ~frame_q;

  // Next-state, frame bookkeeping and marker pulses; all frame decisions
  // happen on the sof cycle, abort overrides everything else.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    rec_frame_d = rec_frame_q;
    rec_start_d = 1'b0;
    rec_end_d   = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    decide      = 1'b0;
    start_rec   = 1'b0;
    cnt_clr     = 1'b0;
    n_idx       = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + FRAME_IDX_W'(1);
    eligible    = n_idx >= START_IDX;

    if (abort) begin
      state_d = ST_IDLE;
      if (state_q == ST_RECORD) begin
        rec_end_d   = 1'b1;
        err_short_d = short_frame;
        err_long_d  = ovf;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d     = ST_ARMED;
            frame_cnt_d = '0;
            dec_cnt_d   = '0;
            cnt_clr     = 1'b1;
          end
        end
        ST_ARMED: begin
          if (sof) decide = 1'b1;
        end
        ST_SKIP, ST_RECORD: begin
          if (sof) begin
            if (state_q == ST_RECORD) begin
              rec_end_d   = 1'b1;
              err_short_d = short_frame;
              err_long_d  = ovf;
            end
            if (frame_cnt_q >= STOP_IDX) state_d = ST_DONE;
            else                         decide  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (decide) begin
      frame_cnt_d = n_idx;
      if (eligible && (dec_cnt_q == '0)) begin
        state_d     = ST_RECORD;
        rec_start_d = 1'b1;
        rec_frame_d = n_idx;
        start_rec   = 1'b1;
        cnt_clr     = 1'b1;
      end else begin
        state_d = ST_SKIP;
      end
      if (eligible) dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + FRAME_IDX_W'(1);
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_SKIP) || (state_d == ST_RECORD);
    done_d = (state_d == ST_DONE);
  end

  // A pixel is recorded when it falls inside an ongoing recorded frame or
  // arrives on the sof cycle that opens a new recorded frame.
  always_comb begin
    cnt_inc = pixel_en && (start_rec || ((state_q == ST_RECORD) && !sof && !abort));
    px_we_d = wr_ok;
    px_x_d  = wr_ok ? wr_x : px_x_q;
    px_y_d  = wr_ok ? wr_y : px_y_q;
  end

  frame_pixel_counter #(
    .W (IMAGE_W),
    .H (IMAGE_H)
  ) u_pix_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .inc         (cnt_inc),
    .wr_ok       (wr_ok),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .short_frame (short_frame),
    .ovf         (ovf)
  );

  // Sequencer state plus all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= 1'b0;
      frame_cnt_q <= '0;
      dec_cnt_q   <= '0;
      rec_frame_q <= '0;
      rec_start_q <= 1'b0;
      rec_end_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      px_we_q     <= 1'b0;
      px_x_q      <= '0;
      px_y_q      <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame;
      frame_cnt_q <= frame_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      rec_frame_q <= rec_frame_d;
      rec_start_q <= rec_start_d;
      rec_end_q   <= rec_end_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      px_we_q     <= px_we_d;
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
    end
  end

  assign px_we     = px_we_q;
  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign rec_start = rec_start_q;
  assign rec_end   = rec_end_q;
  assign rec_frame = rec_frame_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with W=4, H=2. Three instances
// share one stimulus stream: A (start 0, stop 2), B (start 3, stop 5) and
// C (start 1, stop 6, decimate 2).
module tb_frame_capture_ctrl;

  logic clk = 1'b0;
  logic rst, arm, abort, frame, pixel_en;

  logic        a_px_we, a_rec_start, a_rec_end, a_err_short, a_err_long, a_busy, a_done;
  logic [8:0]  a_px_x;
  logic [7:0]  a_px_y;
  logic [15:0] a_rec_frame;
  logic        b_px_we, b_rec_start, b_rec_end, b_err_short, b_err_long, b_busy, b_done;
  logic [8:0]  b_px_x;
  logic [7:0]  b_px_y;
  logic [15:0] b_rec_frame;
  logic        c_px_we, c_rec_start, c_rec_end, c_err_short, c_err_long, c_busy, c_done;
  logic [8:0]  c_px_x;
  logic [7:0]  c_px_y;
  logic [15:0] c_rec_frame;

  int n_checks = 0;
  int n_fail   = 0;

  int we_a = 0, we_b = 0, we_c = 0;
  int re_a = 0, re_b = 0, re_c = 0;
  int er_a = 0, er_b = 0, er_c = 0;
  logic [31:0] mask_a = '0, mask_b = '0, mask_c = '0;

  always #5 clk = ~clk;

  frame_capture_ctrl #(.IMAGE_W(4), .IMAGE_H(2), .START_FRAME(0), .STOP_FRAME(2), .DECIMATE(1)) dut_a (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .frame(frame), .pixel_en(pixel_en),
    .px_we(a_px_we), .px_x(a_px_x), .px_y(a_px_y), .rec_start(a_rec_start), .rec_end(a_rec_end),
    .rec_frame(a_rec_frame), .err_short(a_err_short), .err_long(a_err_long), .busy(a_busy), .done(a_done));

  frame_capture_ctrl #(.IMAGE_W(4), .IMAGE_H(2), .START_FRAME(3), .STOP_FRAME(5), .DECIMATE(1)) dut_b (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .frame(frame), .pixel_en(pixel_en),
    .px_we(b_px_we), .px_x(b_px_x), .px_y(b_px_y), .rec_start(b_rec_start), .rec_end(b_rec_end),
    .rec_frame(b_rec_frame), .err_short(b_err_short), .err_long(b_err_long), .busy(b_busy), .done(b_done));

  frame_capture_ctrl #(.IMAGE_W(4), .IMAGE_H(2), .START_FRAME(1), .STOP_FRAME(6), .DECIMATE(2)) dut_c (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .frame(frame), .pixel_en(pixel_en),
    .px_we(c_px_we), .px_x(c_px_x), .px_y(c_px_y), .rec_start(c_rec_start), .rec_end(c_rec_end),
    .rec_frame(c_rec_frame), .err_short(c_err_short), .err_long(c_err_long), .busy(c_busy), .done(c_done));

  // Event tallies sampled mid-cycle.
  always @(negedge clk) begin
    if (a_px_we) we_a <= we_a + 1;
    if (b_px_we) we_b <= we_b + 1;
    if (c_px_we) we_c <= we_c + 1;
    if (a_rec_end) re_a <= re_a + 1;
    if (b_rec_end) re_b <= re_b + 1;
    if (c_rec_end) re_c <= re_c + 1;
    if (a_rec_end && (a_err_short || a_err_long)) er_a <= er_a + 1;
    if (b_rec_end && (b_err_short || b_err_long)) er_b <= er_b + 1;
    if (c_rec_end && (c_err_short || c_err_long)) er_c <= er_c + 1;
    if (a_rec_start) mask_a[a_rec_frame[4:0]] <= 1'b1;
    if (b_rec_start) mask_b[b_rec_frame[4:0]] <= 1'b1;
    if (c_rec_start) mask_c[c_rec_frame[4:0]] <= 1'b1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, req);
    end
  endtask

  task automatic chkv(input string tag, input int obs, input int req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic do_sof(input logic pix);
    frame = 1'b1;
    pixel_en = pix;
    tick();
    frame = 1'b0;
    pixel_en = 1'b0;
  endtask

  task automatic do_pixels(input int n);
    repeat (n) begin
      pixel_en = 1'b1;
      tick();
    end
    pixel_en = 1'b0;
    tick();
  endtask

  int snap_we, snap_re;

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; frame = 1'b0; pixel_en = 1'b0;
    tick();
    tick();
    chk1("reset px_we", a_px_we, 1'b0);
    chk1("reset rec_start", a_rec_start, 1'b0);
    chk1("reset rec_end", a_rec_end, 1'b0);
    chk1("reset busy", a_busy, 1'b0);
    chk1("reset done", a_done, 1'b0);
    chkv("reset rec_frame", 32'(a_rec_frame), 0);
    rst = 1'b0;
    tick();

    // Normal session: seven frames of eight pixels each.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk1("armed busy", a_busy, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      do_sof(1'b0);
      chk1("a done", a_done, k >= 3);
      chk1("b done", b_done, k >= 6);
      chk1("c done", c_done, k >= 7);
      chk1("a rec_start", a_rec_start, k <= 2);
      chk1("a rec_end", a_rec_end, (k == 2) || (k == 3));
      if (k <= 2) chkv("a rec_frame", 32'(a_rec_frame), k);
      for (int i = 0; i < 8; i++) begin
        pixel_en = 1'b1;
        tick();
        if (k == 1) begin
          chk1("a f1 px_we", a_px_we, 1'b1);
          chkv("a f1 px_x", 32'(a_px_x), i % 4);
          chkv("a f1 px_y", 32'(a_px_y), i / 4);
        end
      end
      pixel_en = 1'b0;
      tick();
    end
    chkv("a px_we total", we_a, 16);
    chkv("b px_we total", we_b, 24);
    chkv("c px_we total", we_c, 24);
    chkv("a recorded set", int'(mask_a), 32'h06);
    chkv("b recorded set", int'(mask_b), 32'h38);
    chkv("c recorded set", int'(mask_c), 32'h2A);
    chkv("a rec_end count", re_a, 2);
    chkv("b rec_end count", re_b, 3);
    chkv("c rec_end count", re_c, 3);
    chkv("a err count", er_a, 0);
    chkv("b err count", er_b, 0);
    chkv("c err count", er_c, 0);

    // Short frame then long frame.
    snap_we = we_a;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk1("rearm done drop", a_done, 1'b0);
    do_sof(1'b0);
    chk1("short rec_start", a_rec_start, 1'b1);
    do_pixels(6);
    do_sof(1'b0);
    chk1("short rec_end", a_rec_end, 1'b1);
    chk1("short err_short", a_err_short, 1'b1);
    chk1("short err_long", a_err_long, 1'b0);
    chkv("long rec_frame", 32'(a_rec_frame), 2);
    do_pixels(10);
    chkv("short+long px_we", we_a - snap_we, 14);
    do_sof(1'b0);
    chk1("long rec_end", a_rec_end, 1'b1);
    chk1("long err_short", a_err_short, 1'b0);
    chk1("long err_long", a_err_long, 1'b1);
    chk1("long done", a_done, 1'b1);
    tick();
    chk1("err_long idle", a_err_long, 1'b0);
    chk1("rec_end idle", a_rec_end, 1'b0);

    // Abort mid-record, then arm+abort together.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    do_sof(1'b0);
    chk1("abort rec_start", a_rec_start, 1'b1);
    do_pixels(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("abort rec_end", a_rec_end, 1'b1);
    chk1("abort err_short", a_err_short, 1'b1);
    chk1("abort err_long", a_err_long, 1'b0);
    chk1("abort busy", a_busy, 1'b0);
    snap_we = we_a;
    do_sof(1'b0);
    chk1("idle sof rec_start", a_rec_start, 1'b0);
    chk1("idle sof busy", a_busy, 1'b0);
    do_pixels(4);
    chkv("idle px_we", we_a - snap_we, 0);
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    chk1("arm+abort busy", a_busy, 1'b0);
    chk1("arm+abort done", a_done, 1'b0);
    tick();
    chk1("arm+abort busy later", a_busy, 1'b0);

    // Pixel on the sof cycle, then reset mid-frame.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    do_sof(1'b1);
    chk1("sof pix rec_start", a_rec_start, 1'b1);
    chk1("sof pix px_we", a_px_we, 1'b1);
    chkv("sof pix px_x", 32'(a_px_x), 0);
    chkv("sof pix px_y", 32'(a_px_y), 0);
    pixel_en = 1'b1;
    tick();
    chkv("2nd pix px_x", 32'(a_px_x), 1);
    tick();
    chkv("3rd pix px_x", 32'(a_px_x), 2);
    snap_re = re_a;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pixel_en = 1'b0;
    chk1("rst px_we", a_px_we, 1'b0);
    chkv("rst px_x", 32'(a_px_x), 0);
    chkv("rst px_y", 32'(a_px_y), 0);
    chk1("rst rec_end", a_rec_end, 1'b0);
    chk1("rst busy", a_busy, 1'b0);
    chk1("rst done", a_done, 1'b0);
    chkv("rst rec_frame", 32'(a_rec_frame), 0);
    chk1("rst err_short", a_err_short, 1'b0);
    tick();
    tick();
    do_sof(1'b0);
    tick();
    chkv("no rec_end after rst", re_a - snap_re, 0);
    chk1("post rst busy", a_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
Synthesizable sequencer for the video frame-capture path. It watches the PPU frame strobe and pixel strobe and decides which frames are recorded: start frame, stop frame, and decimation. It gates the pixel strobe into a write enable and generates per-pixel x/y coordinates. It also emits start/end markers and size-error flags for the downstream frame buffer or PPM dump sink. It sits between the PPU pixel output and any capture sink, and replaces ad-hoc frame counting in sinks.

Parameters:
IMAGE_W, 256, pixels per line
IMAGE_H, 240, lines per frame
START_FRAME, 0, first frame index eligible for recording (frames numbered from 1 after arm)
STOP_FRAME, 2, last frame index recorded; capture ends at the frame edge after it
DECIMATE, 1, record every DECIMATE-th eligible frame (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
arm  in  1  pulse; starts a capture session from IDLE or DONE
abort  in  1  pulse; returns to IDLE from any state
frame  in  1  PPU frame strobe; its rising edge (sof) marks start of frame
pixel_en  in  1  one valid pixel this cycle
px_we  out  1  pixel_en gated: recording and in-frame pixel count < IMAGE_W*IMAGE_H
px_x  out  9  column of the pixel qualified by px_we
px_y  out  8  row of the pixel qualified by px_we
rec_start  out  1  1-cycle pulse; a recorded frame begins
rec_end  out  1  1-cycle pulse; a recorded frame closes
rec_frame  out  16  index of the frame currently or last recorded
err_short  out  1  valid with rec_end; frame had fewer than W*H pixels
err_long  out  1  valid with rec_end; frame had more than W*H pixels
busy  out  1  state is ARMED, SKIP or RECORD
done  out  1  level; state is DONE

Behaviour:
- frame_q is frame registered. sof = frame & ~frame_q, combinational. All decisions are taken at the clock edge of the sof cycle.
- Reset: state IDLE. frame_q, frame_cnt, dec_cnt, pix_cnt, rec_frame are 0. All outputs are 0.
- States: IDLE, ARMED, SKIP, RECORD, DONE.
- IDLE/DONE + arm -> ARMED. Clears frame_cnt, dec_cnt and pix_cnt. done drops.
- ARMED + sof -> run the decide step.
- SKIP/RECORD + sof:
  - If in RECORD, pulse rec_end together with err_short/err_long for the closing frame.
  - Then, if frame_cnt >= STOP_FRAME, go to DONE.
  - Otherwise run the decide step.
- Decide step:
  - n = frame_cnt+1, saturating at 16'hFFFF. frame_cnt <= n.
  - Eligible when n >= START_FRAME.
  - If eligible and dec_cnt == 0: go to RECORD, pulse rec_start, rec_frame <= n, pix_cnt <= 0.
  - Otherwise go to SKIP.
  - For every eligible frame, dec_cnt <= (dec_cnt == DECIMATE-1) ? 0 : dec_cnt+1.
- Latency: rec_start, rec_end and the state change are visible one cycle after the sof cycle.
- Pixels:
  - pixel_en in the sof cycle belongs to the new frame.
  - If that new frame is recorded, the pixel is written at (0,0) and px_we rises in the same cycle as rec_start (both registered).
  - px_we, px_x and px_y are registered, so they trail pixel_en by 1 cycle.
  - px_x counts 0..IMAGE_W-1 and wraps into px_y++. At pix_cnt == W*H, px_we is suppressed and the long flag is set.
- err_short = pix_cnt < W*H at close; err_long = overflow flag. Both are 0 except in a rec_end cycle.
- abort:
  - From any state -> IDLE.
  - From RECORD, pulses rec_end, with err_short per the current count.
  - abort beats arm when both are asserted in the same cycle.
  - abort beats sof when both are asserted in the same cycle.
- arm while busy is ignored.
- DONE holds until arm, abort or rst. No px_we in DONE.
- rst mid-RECORD: immediate IDLE, no rec_end.

Decomposition:
- frame_capture_pkg holds:
  - typedef enum logic [2:0] cap_state_t for the five states
  - FRAME_IDX_W=16
  - function px_total(W,H)
- One sub-module, frame_pixel_counter: x/y/count registers with clear, inc, overflow flag, and parameters W and H.

Test Plan:
1. Bench parameters for all tests: W=4, H=2, START=0, STOP=2, DECIMATE=1. arm, then 3 sof edges each followed by 8 pixel_en -> rec_start with rec_frame=1 and rec_frame=2. 16 px_we total, the first frame's coordinates (0,0)..(3,1). Two rec_end with no errors. done=1 after the 3rd sof edge.
2. START=3, STOP=5 -> frames 1 and 2 skip (no px_we). Frames 3, 4 and 5 are recorded. DONE after the 6th edge.
3. DECIMATE=2, START=1, STOP=6 -> frames 1, 3 and 5 are recorded. Frames 2, 4 and 6 are skipped. done after the 7th edge.
4. Frame with 6 pixels -> rec_end with err_short=1. Frame with 10 pixels -> 8 px_we, then rec_end with err_long=1.
5. abort in the middle of RECORD after 3 pixels -> rec_end with err_short=1, then IDLE; a subsequent sof has no effect. arm and abort in the same cycle -> stays IDLE.
6. pixel_en in the sof cycle -> px_we with (0,0) in the rec_start cycle. rst asserted mid-frame -> all outputs 0 on the next cycle, and no rec_end.
